// File: rtl/cr_clic_pkg.sv
// Shared types and constants for the CLIC interrupt delivery controller.
package cr_clic_pkg;

  localparam int unsigned IdWidthDef = 12;
  localparam int unsigned IlWidthDef = 8;
  localparam int unsigned HoldCntW   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPend  = 2'd1,
    StClaim = 2'd2,
    StHold  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/cr_clic_int_ctrl_if.sv
// Arbiter, core and kid-array signals of the interrupt delivery controller.
interface cr_clic_int_ctrl_if
  import cr_clic_pkg::*;
#(
  parameter int unsigned ID_WIDTH = IdWidthDef,
  parameter int unsigned IL_WIDTH = IlWidthDef
);
  logic [ID_WIDTH-1:0] arb_ctrl_int_id;
  logic [IL_WIDTH-1:0] arb_ctrl_int_il;
  logic                arb_ctrl_int_hv;
  logic                arb_ctrl_int_mode;
  logic                cp_clic_mie;
  logic [IL_WIDTH-1:0] cp_clic_mil;
  logic [IL_WIDTH-1:0] cp_clic_mintthresh;
  logic                cpu_clic_int_ack;
  logic                clic_cpu_int_vld;
  logic [ID_WIDTH-1:0] clic_cpu_int_id;
  logic [IL_WIDTH-1:0] clic_cpu_int_il;
  logic                clic_cpu_int_hv;
  logic                clic_cpu_int_mode;
  logic                ctrl_kid_claim_vld;
  logic [ID_WIDTH-1:0] ctrl_kid_claim_id;
  logic                ctrl_clk_en;

  modport master (
    output arb_ctrl_int_id, arb_ctrl_int_il, arb_ctrl_int_hv, arb_ctrl_int_mode,
           cp_clic_mie, cp_clic_mil, cp_clic_mintthresh, cpu_clic_int_ack,
    input  clic_cpu_int_vld, clic_cpu_int_id, clic_cpu_int_il, clic_cpu_int_hv,
           clic_cpu_int_mode, ctrl_kid_claim_vld, ctrl_kid_claim_id, ctrl_clk_en
  );

  modport slave (
    input  arb_ctrl_int_id, arb_ctrl_int_il, arb_ctrl_int_hv, arb_ctrl_int_mode,
           cp_clic_mie, cp_clic_mil, cp_clic_mintthresh, cpu_clic_int_ack,
    output clic_cpu_int_vld, clic_cpu_int_id, clic_cpu_int_il, clic_cpu_int_hv,
           clic_cpu_int_mode, ctrl_kid_claim_vld, ctrl_kid_claim_id, ctrl_clk_en
  );
endinterface

// File: rtl/cr_clic_lvl_qual.sv
// Eligibility of one interrupt level against mie, mil and the threshold.
module cr_clic_lvl_qual
  import cr_clic_pkg::*;
#(
  parameter int unsigned IL_WIDTH = IlWidthDef
) (
  input  logic                mie,
  input  logic [IL_WIDTH-1:0] il,
  input  logic [IL_WIDTH-1:0] mil,
  input  logic [IL_WIDTH-1:0] thresh,
  output logic                elig
);
  logic [IL_WIDTH-1:0] floor_lvl;

  always_comb begin
    floor_lvl = (mil > thresh) ? mil : thresh;
    elig      = mie && (il != '0) && (il > floor_lvl);
  end
endmodule

// File: rtl/cr_clic_int_ctrl.sv
// Presents the registered arbiter winner to the core, claims it on ack and
// holds off re-presentation until the cleared pending has propagated back.
module cr_clic_int_ctrl
  import cr_clic_pkg::*;
#(
  parameter int unsigned ID_WIDTH = IdWidthDef,
  parameter int unsigned IL_WIDTH = IlWidthDef,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic               out_clk,
  input  logic               cpurst,
  cr_clic_int_ctrl_if.slave  bus
);
  localparam logic [HoldCntW-1:0] HoldLoad = HoldCntW'(HOLD_CYC - 1);

  logic [ID_WIDTH-1:0] cand_id_q, int_id_q, claim_id_q;
  logic [IL_WIDTH-1:0] cand_il_q, int_il_q;
  logic                cand_hv_q, cand_mode_q, int_hv_q, int_mode_q;
  logic                int_vld_q, claim_vld_q;
  logic [HoldCntW-1:0] cnt_q;
  ctrl_state_e         state_q;
  logic                cand_elig, lat_elig;

  cr_clic_lvl_qual #(.IL_WIDTH(IL_WIDTH)) u_cand_qual (
    .mie    (bus.cp_clic_mie),
    .il     (cand_il_q),
    .mil    (bus.cp_clic_mil),
    .thresh (bus.cp_clic_mintthresh),
    .elig   (cand_elig)
  );

  cr_clic_lvl_qual #(.IL_WIDTH(IL_WIDTH)) u_lat_qual (
    .mie    (bus.cp_clic_mie),
    .il     (int_il_q),
    .mil    (bus.cp_clic_mil),
    .thresh (bus.cp_clic_mintthresh),
    .elig   (lat_elig)
  );

  always_ff @(posedge out_clk or posedge cpurst) begin
    if (cpurst) begin
      cand_id_q   <= '0;
      cand_il_q   <= '0;
      cand_hv_q   <= 1'b0;
      cand_mode_q <= 1'b0;
    end else begin
      cand_id_q   <= bus.arb_ctrl_int_id;
      cand_il_q   <= bus.arb_ctrl_int_il;
      cand_hv_q   <= bus.arb_ctrl_int_hv;
      cand_mode_q <= bus.arb_ctrl_int_mode;
    end
  end

  always_ff @(posedge out_clk or posedge cpurst) begin
    if (cpurst) begin
      state_q     <= StIdle;
      int_vld_q   <= 1'b0;
      int_id_q    <= '0;
      int_il_q    <= '0;
      int_hv_q    <= 1'b0;
      int_mode_q  <= 1'b0;
      claim_vld_q <= 1'b0;
      claim_id_q  <= '0;
      cnt_q       <= '0;
    end else begin
      claim_vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          int_vld_q <= 1'b0;
          if (cand_elig) begin
            state_q    <= StPend;
            int_vld_q  <= 1'b1;
            int_id_q   <= cand_id_q;
            int_il_q   <= cand_il_q;
            int_hv_q   <= cand_hv_q;
            int_mode_q <= cand_mode_q;
          end
        end
        StPend: begin
          // Ack wins over withdrawal and reload in the same cycle.
          if (bus.cpu_clic_int_ack) begin
            state_q     <= StClaim;
            int_vld_q   <= 1'b0;
            claim_vld_q <= 1'b1;
            claim_id_q  <= int_id_q;
          end else if (!lat_elig) begin
            state_q   <= StIdle;
            int_vld_q <= 1'b0;
          end else if (cand_elig && (cand_il_q > int_il_q)) begin
            int_id_q   <= cand_id_q;
            int_il_q   <= cand_il_q;
            int_hv_q   <= cand_hv_q;
            int_mode_q <= cand_mode_q;
          end
        end
        StClaim: begin
          state_q <= StHold;
          cnt_q   <= HoldLoad;
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - HoldCntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.clic_cpu_int_vld   = int_vld_q;
  assign bus.clic_cpu_int_id    = int_id_q;
  assign bus.clic_cpu_int_il    = int_il_q;
  assign bus.clic_cpu_int_hv    = int_hv_q;
  assign bus.clic_cpu_int_mode  = int_mode_q;
  assign bus.ctrl_kid_claim_vld = claim_vld_q;
  assign bus.ctrl_kid_claim_id  = claim_id_q;
  assign bus.ctrl_clk_en = (state_q != StIdle) | (bus.arb_ctrl_int_il != '0) | (cand_il_q != '0);

endmodule
